// File: rtl/hsv_core_commit_queue.sv
// ============================================================================
// Module   : hsv_core_commit_queue
// Purpose  : Per-execution-unit result queue that sits in front of commit.
//            Results are buffered in issue order. The head entry is presented
//            to commit, which pops it when its commit token matches. This lets
//            the unit keep executing while its oldest result waits for commit.
//            The global flush clears the queue.
// Ports    : clk_core    - core clock
//            rst_core_n  - synchronous active-low reset
//            flush_req   - global flush; empties the queue and blocks traffic
//            in_data     - result from the execution unit
//            in_valid    - the unit presents a result
//            in_ready    - the queue accepts in_data this cycle
//            out_data    - head entry (all zeros when out_valid is low)
//            out_valid   - the head entry is valid
//            out_ready   - commit token match; pops the head
//            count       - current occupancy, 0..DEPTH
//            full        - count == DEPTH
//            empty       - count == 0
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsv_core_commit_queue #(
  parameter int DEPTH  = 4,   // power of two, >= 2
  parameter int DATA_W = 64   // $bits(commit_data_t)
) (
  input  logic                        clk_core,
  input  logic                        rst_core_n,
  input  logic                        flush_req,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        full,
  output logic                        empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Full/empty decode from the explicit occupancy count, not from pointers.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // No bypass: a pop in the same cycle never opens a full queue.
  assign in_ready  = !w_full && !flush_req;
  assign out_valid = !w_empty && !flush_req;
  // Zero when not valid so commit can OR-reduce the unit outputs.
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;

  // Pointer and occupancy state. Reset dominates flush; flush dominates
  // push/pop (already blocked through in_ready/out_valid).
  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_req) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; stale entries are never visible
  // because out_data is masked by out_valid.
  always_ff @(posedge clk_core) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Occupancy can never exceed DEPTH since pushes are gated by in_ready.
  always_ff @(posedge clk_core) begin
    if (rst_core_n) begin
      assert (r_count <= CNT_W'(DEPTH))
        else $error("commit queue occupancy above DEPTH");
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hsv_core_commit_queue.sv
// ============================================================================
// Module   : tb_hsv_core_commit_queue
// Purpose  : Self-checking bench for hsv_core_commit_queue. A queue-based
//            reference model predicts every output each cycle; directed
//            phases are followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hsv_core_commit_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_core = 1'b0;
  logic          rst_core_n;
  logic          flush_req;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  always #5 clk_core = ~clk_core;

  hsv_core_commit_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DW)
  ) u_dut (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .flush_req  (flush_req),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // Reference model: queue contents in issue order.
  logic [DW-1:0] mq[$];
  bit            model_valid = 1'b0;
  int            n_pass  = 0;
  int            n_total = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic cyc(input logic rn, input logic fl, input logic iv,
                     input logic [DW-1:0] d, input logic ordy);
    int       sz;
    logic     e_ir;
    logic     e_ov;
    logic [DW-1:0] e_dat;
    rst_core_n = rn;
    flush_req  = fl;
    in_valid   = iv;
    in_data    = d;
    out_ready  = ordy;
    @(negedge clk_core);
    sz    = mq.size();
    e_ir  = (sz < DEPTH) && !fl;
    e_ov  = (sz > 0) && !fl;
    e_dat = e_ov ? mq[0] : '0;
    if (model_valid) begin
      check("count",     64'(count),     64'(sz));
      check("empty",     64'(empty),     64'(sz == 0));
      check("full",      64'(full),      64'(sz == DEPTH));
      check("in_ready",  64'(in_ready),  64'(e_ir));
      check("out_valid", 64'(out_valid), 64'(e_ov));
      check("out_data",  64'(out_data),  64'(e_dat));
    end
    @(posedge clk_core);
    #1;
    if (!rn) begin
      mq.delete();
      model_valid = 1'b1;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (e_ov && ordy) void'(mq.pop_front());
      if (iv && e_ir) mq.push_back(d);
    end
  endtask

  initial begin
    rst_core_n = 1'b0;
    flush_req  = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;

    // Reset for two cycles, then idle cycles check reset values.
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Latency and ordering: A, B, C on consecutive cycles, commit always ready.
    cyc(1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'h104, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'h108, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Fill with backpressure: six offers, only four accepted, head stable.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 32'h200 + 32'(i), 1'b0);

    // Full with simultaneous pop: pop only, then push and pop.
    cyc(1'b1, 1'b0, 1'b1, 32'h300, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'h304, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Wrap-around with alternating commit stalls.
    for (int i = 0; i < 24; i++)
      cyc(1'b1, 1'b0, 1'b1, 32'h400 + 32'(i), logic'(i % 2));
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Flush: three queued, flush held two cycles with in_valid high.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 32'h500 + 32'(i), 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'h5AA, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 32'h5BB, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'h5CC, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic including occasional flush and mid-run reset.
    for (int i = 0; i < 400; i++) begin
      cyc(logic'($urandom_range(0, 49) != 0),
          logic'($urandom_range(0, 15) == 0),
          logic'($urandom_range(0, 3) != 0),
          DW'($urandom),
          logic'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
